// File: rtl/pfb_bypass_pkg.sv
// Shared types and widths for the PFB / window-only path switch.
package pfb_bypass_pkg;

    typedef enum logic [1:0] {
        STEADY = 2'd0,
        ARMED  = 2'd1,
        FLUSH  = 2'd2
    } state_e;

    localparam int FLUSH_CNT_W  = 4;
    localparam int SWITCH_CNT_W = 16;

    // Increment that sticks at all-ones instead of wrapping.
    function automatic logic [SWITCH_CNT_W-1:0] sat_inc(input logic [SWITCH_CNT_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

endpackage

// File: rtl/pfb_bypass_fsm.sv
// Path-switch sequencer: arms on a request change, switches on a frame sync,
// then holds the output blanked for FLUSH_FRAMES frames.
module pfb_bypass_fsm
    import pfb_bypass_pkg::*;
#(
    parameter int FLUSH_FRAMES = 2
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    req,
    input  logic                    sync_in,
    input  logic                    clr_rise,
    output logic                    bypass_active,
    output logic                    flushing,
    output logic                    bypass_nxt,
    output logic                    flushing_nxt,
    output logic [SWITCH_CNT_W-1:0] switch_count,
    output state_e                  state
);

    state_e                  state_q, state_nxt;
    logic [FLUSH_CNT_W-1:0]  flush_cnt_q, flush_cnt_nxt;
    logic                    bypass_q;
    logic [SWITCH_CNT_W-1:0] count_q, count_nxt;
    logic                    do_switch;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= STEADY;
            flush_cnt_q <= '0;
            bypass_q    <= 1'b0;
            count_q     <= '0;
        end else begin
            state_q     <= state_nxt;
            flush_cnt_q <= flush_cnt_nxt;
            bypass_q    <= bypass_nxt;
            count_q     <= count_nxt;
        end
    end

    always_comb begin
        state_nxt     = state_q;
        flush_cnt_nxt = flush_cnt_q;
        bypass_nxt    = bypass_q;
        do_switch     = 1'b0;
        case (state_q)
            STEADY: begin
                if (req != bypass_q) state_nxt = ARMED;
            end
            ARMED: begin
                if (req == bypass_q) begin
                    state_nxt = STEADY;
                end else if (sync_in) begin
                    bypass_nxt    = ~bypass_q;
                    do_switch     = 1'b1;
                    flush_cnt_nxt = FLUSH_FRAMES[FLUSH_CNT_W-1:0];
                    state_nxt     = FLUSH;
                end
            end
            FLUSH: begin
                // The sync that empties the counter starts the first clean frame.
                if (sync_in) begin
                    if (flush_cnt_q <= 1) begin
                        flush_cnt_nxt = '0;
                        state_nxt     = STEADY;
                    end else begin
                        flush_cnt_nxt = flush_cnt_q - 1'b1;
                    end
                end
            end
            default: state_nxt = STEADY;
        endcase

        flushing_nxt = (state_nxt == FLUSH);

        if (clr_rise)       count_nxt = '0;
        else if (do_switch) count_nxt = sat_inc(count_q);
        else                count_nxt = count_q;
    end

    assign bypass_active = bypass_q;
    assign flushing      = (state_q == FLUSH);
    assign switch_count  = count_q;
    assign state         = state_q;

endmodule

// File: rtl/pfb_bypass_switch.sv
// Selects PFB or window-only samples for the FFT, switching only at frame
// boundaries and blanking the output while the FFT pipeline flushes.
module pfb_bypass_switch
    import pfb_bypass_pkg::*;
#(
    parameter int DATA_W       = 36,
    parameter int SEL_BIT      = 0,
    parameter int CLR_BIT      = 31,
    parameter int FLUSH_FRAMES = 2
) (
    input  logic                    user_clk,
    input  logic                    user_rst_n,
    input  logic [31:0]             ctrl_word,
    input  logic                    sync_in,
    input  logic [DATA_W-1:0]       pfb_data,
    input  logic [DATA_W-1:0]       win_data,
    input  logic                    din_valid,
    output logic [DATA_W-1:0]       dout,
    output logic                    dout_valid,
    output logic                    sync_out,
    output logic                    bypass_active,
    output logic                    flushing,
    output logic [SWITCH_CNT_W-1:0] switch_count
);

    logic [31:0] ctrl_q;
    logic        clr_q;
    logic        req, clr_rise;
    logic        bypass_nxt, flushing_nxt;
    state_e      fsm_state;
    logic        unused_bits;

    always_ff @(posedge user_clk or negedge user_rst_n) begin
        if (!user_rst_n) begin
            ctrl_q <= '0;
            clr_q  <= 1'b0;
        end else begin
            ctrl_q <= ctrl_word;
            clr_q  <= ctrl_q[CLR_BIT];
        end
    end

    assign req      = ctrl_q[SEL_BIT];
    assign clr_rise = ctrl_q[CLR_BIT] & ~clr_q;

    // Only two control bits matter; the FSM state is kept for probing.
    assign unused_bits = ^{ctrl_q, fsm_state};

    pfb_bypass_fsm #(
        .FLUSH_FRAMES(FLUSH_FRAMES)
    ) u_fsm (
        .clk          (user_clk),
        .rst_n        (user_rst_n),
        .req          (req),
        .sync_in      (sync_in),
        .clr_rise     (clr_rise),
        .bypass_active(bypass_active),
        .flushing     (flushing),
        .bypass_nxt   (bypass_nxt),
        .flushing_nxt (flushing_nxt),
        .switch_count (switch_count),
        .state        (fsm_state)
    );

    // The mux looks at next-state values so the switching sync sample
    // already belongs to the new path and to the blanked window.
    always_ff @(posedge user_clk or negedge user_rst_n) begin
        if (!user_rst_n) begin
            dout       <= '0;
            dout_valid <= 1'b0;
            sync_out   <= 1'b0;
        end else begin
            sync_out <= sync_in;
            if (flushing_nxt) begin
                dout       <= '0;
                dout_valid <= 1'b0;
            end else begin
                dout_valid <= din_valid;
                if (din_valid) dout <= bypass_nxt ? win_data : pfb_data;
            end
        end
    end

endmodule

// File: tb/tb_pfb_bypass_switch.sv
// Self-checking bench for pfb_bypass_switch: table of directed phases,
// hand-written clear/reset sequences and a randomized run against a frame-level model.
module tb_pfb_bypass_switch;

    localparam int DATA_W = 36;
    localparam int FLUSH  = 2;

    logic              user_clk = 1'b0;
    logic              user_rst_n;
    logic [31:0]       ctrl_word;
    logic              sync_in;
    logic [DATA_W-1:0] pfb_data, win_data;
    logic              din_valid;
    logic [DATA_W-1:0] dout;
    logic              dout_valid, sync_out, bypass_active, flushing;
    logic [15:0]       switch_count;

    always #5 user_clk = ~user_clk;

    pfb_bypass_switch #(
        .DATA_W(DATA_W), .SEL_BIT(0), .CLR_BIT(31), .FLUSH_FRAMES(FLUSH)
    ) dut (
        .user_clk     (user_clk),
        .user_rst_n   (user_rst_n),
        .ctrl_word    (ctrl_word),
        .sync_in      (sync_in),
        .pfb_data     (pfb_data),
        .win_data     (win_data),
        .din_valid    (din_valid),
        .dout         (dout),
        .dout_valid   (dout_valid),
        .sync_out     (sync_out),
        .bypass_active(bypass_active),
        .flushing     (flushing),
        .switch_count (switch_count)
    );

    int errors = 0;
    int checks = 0;
    int cyc    = 0;
    int blank_cycles = 0;

    // Reference model: path, pending request, frames left to blank, count.
    logic              m_bypass, m_armed, m_dv, m_sync, q2;
    int                m_blank, m_count;
    logic [DATA_W-1:0] m_dout;
    logic [31:0]       q1;

    typedef struct {
        logic [31:0] ctrl;
        int          ncyc;
        logic        exp_bypass;
        logic        exp_flush;
        logic [15:0] exp_count;
    } vec_t;
    vec_t tbl[15];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at cyc %0d: got %h expected %h", name, cyc, act, exp);
        end
    endtask

    function automatic logic [DATA_W-1:0] rnd_word();
        logic [63:0] r;
        r = {$urandom, $urandom};
        return r[DATA_W-1:0];
    endfunction

    task automatic model_reset();
        m_bypass = 0; m_armed = 0; m_blank = 0; m_count = 0;
        m_dout = '0; m_dv = 0; m_sync = 0; q1 = '0; q2 = 0;
    endtask

    task automatic model_step();
        logic req, clr_rise, switched;
        req      = q1[0];
        clr_rise = q1[31] & ~q2;
        switched = 0;
        if (m_blank > 0) begin
            if (sync_in) m_blank--;
        end else if (m_armed) begin
            if (req == m_bypass) m_armed = 0;
            else if (sync_in) begin
                m_bypass = ~m_bypass;
                m_blank  = FLUSH;
                switched = 1;
                m_armed  = 0;
            end
        end else if (req != m_bypass) begin
            m_armed = 1;
        end
        if (clr_rise) m_count = 0;
        else if (switched && m_count < 65535) m_count++;
        m_sync = sync_in;
        if (m_blank > 0) begin
            m_dout = '0;
            m_dv   = 0;
        end else begin
            m_dv = din_valid;
            if (din_valid) m_dout = m_bypass ? win_data : pfb_data;
        end
        q2 = q1[31];
        q1 = ctrl_word;
    endtask

    task automatic step(input logic [31:0] cw, input logic s, input logic dv);
        logic [15:0] mc;
        ctrl_word = cw;
        sync_in   = s;
        din_valid = dv;
        pfb_data  = rnd_word();
        win_data  = rnd_word();
        @(posedge user_clk);
        model_step();
        #1;
        mc = m_count[15:0];
        check("outputs",
              {8'd0, dout, dout_valid, sync_out, bypass_active, flushing, switch_count},
              {8'd0, m_dout, m_dv, m_sync, m_bypass, (m_blank > 0), mc});
        if (!dout_valid) blank_cycles++;
        cyc++;
    endtask

    task automatic run(input logic [31:0] cw, input int n);
        for (int i = 0; i < n; i++) step(cw, (cyc % 8) == 0, 1'b1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        logic [31:0] rcw;
        user_rst_n = 0;
        ctrl_word = '0; sync_in = 0; din_valid = 0; pfb_data = '0; win_data = '0;
        model_reset();
        repeat (3) @(posedge user_clk);
        #1;
        check("reset_dout", {28'd0, dout}, 64'd0);
        check("reset_flags", {60'd0, dout_valid, sync_out, bypass_active, flushing}, 64'd0);
        check("reset_count", {48'd0, switch_count}, 64'd0);
        user_rst_n = 1;

        tbl[0]  = '{32'h0,         20, 1'b0, 1'b0, 16'd0};
        tbl[1]  = '{32'h1,          8, 1'b1, 1'b1, 16'd1};
        tbl[2]  = '{32'h1,         16, 1'b1, 1'b0, 16'd1};
        tbl[3]  = '{32'h0,          2, 1'b1, 1'b0, 16'd1};
        tbl[4]  = '{32'h1,         10, 1'b1, 1'b0, 16'd1};
        tbl[5]  = '{32'h0,          4, 1'b1, 1'b0, 16'd1};
        tbl[6]  = '{32'h0,          8, 1'b0, 1'b1, 16'd2};
        tbl[7]  = '{32'h1,          4, 1'b0, 1'b1, 16'd2};
        tbl[8]  = '{32'h0,          4, 1'b0, 1'b1, 16'd2};
        tbl[9]  = '{32'h1,          4, 1'b0, 1'b1, 16'd2};
        tbl[10] = '{32'h1,          8, 1'b0, 1'b0, 16'd2};
        tbl[11] = '{32'h1,          8, 1'b1, 1'b1, 16'd3};
        tbl[12] = '{32'h1,         16, 1'b1, 1'b0, 16'd3};
        tbl[13] = '{32'h8000_0001,  2, 1'b1, 1'b0, 16'd0};
        tbl[14] = '{32'h1,          6, 1'b1, 1'b0, 16'd0};

        blank_cycles = 0;
        for (int i = 0; i < 15; i++) begin
            run(tbl[i].ctrl, tbl[i].ncyc);
            check($sformatf("table[%0d]", i),
                  {46'd0, bypass_active, flushing, switch_count},
                  {46'd0, tbl[i].exp_bypass, tbl[i].exp_flush, tbl[i].exp_count});
        end
        // Three committed switches, each blanking two 8-cycle frames.
        check("blank_cycles", blank_cycles, 64'd48);

        for (int i = 0; i < 5; i++) run((i % 2 == 0) ? 32'h0 : 32'h1, 32);
        check("count_five", {47'd0, bypass_active, switch_count}, {47'd0, 1'b0, 16'd5});
        run(32'h8000_0000, 1);
        run(32'h0, 3);
        check("clear_pulse", {48'd0, switch_count}, 64'd0);
        run(32'h0, 4);
        run(32'h8000_0001, 32);
        run(32'h8000_0000, 32);
        check("clear_held", {47'd0, bypass_active, switch_count}, {47'd0, 1'b0, 16'd2});

        run(32'h1, 12);
        check("pre_reset_flush", {62'd0, bypass_active, flushing}, {62'd0, 1'b1, 1'b1});
        #1 user_rst_n = 0;
        #1;
        check("async_reset_dout", {27'd0, dout, dout_valid}, 64'd0);
        check("async_reset_state", {46'd0, bypass_active, flushing, switch_count}, 64'd0);
        repeat (2) @(posedge user_clk);
        #1 user_rst_n = 1;
        model_reset();
        run(32'h1, 40);
        check("rearm_after_reset", {46'd0, bypass_active, flushing, switch_count},
              {46'd0, 1'b1, 1'b0, 16'd1});

        rcw = 32'h0;
        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(0, 19) == 0) rcw[0] = ~rcw[0];
            if ($urandom_range(0, 29) == 0) rcw[31] = ~rcw[31];
            rcw[30:1] = $urandom;
            step(rcw, $urandom_range(0, 4) == 0, $urandom_range(0, 3) != 0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
